// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and default width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CARRY = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/full_adder_1b.sv
// One-bit full adder; purely combinational, zero latency, no flow control.
module full_adder_1b (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one bit pair per cycle through a single full adder, LSB first.
// Latency WIDTH+1 edges from accepted start to done; start is ignored unless IDLE.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   res_q, res_d;

  logic fa_s, fa_co;
  logic shift_en, shift_bit, res_clr;

  full_adder_1b u_fa (
    .x  (opa_q[0]),
    .y  (opb_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    shift_en  = 1'b0;
    shift_bit = 1'b0;
    res_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          cnt_d   = '0;
          res_clr = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        shift_en  = 1'b1;
        shift_bit = fa_s;
        carry_d   = fa_co;
        opa_d     = opa_q >> 1;
        opb_d     = opb_q >> 1;
        // Counter parks on the last index so it never wraps inside a run.
        if (cnt_q == LAST_BIT) begin
          state_d = CARRY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CARRY: begin
        shift_en  = 1'b1;
        shift_bit = carry_q;
        state_d   = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Right-shifting, MSB-in, enable-gated result register.
  always_comb begin
    res_d = res_q;
    if (res_clr) begin
      res_d = '0;
    end else if (shift_en) begin
      res_d = {shift_bit, res_q[WIDTH:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign busy = (state_q == RUN) || (state_q == CARRY);
  assign done = (state_q == DONE);
  assign sum  = res_q;

endmodule
